riscv_ifetch_buf: RTL
=====================

Name: riscv_ifetch_buf

Overview:
- Parametrised successor to the current pc_reg + ifetch + if_id front end.
- Owns the PC and issues pipelined requests to instruction memory (req/gnt/rvalid, in-order, variable latency).
- Buffers returned instructions in a FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (jump/branch) from EX, including discarding responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2.
- CNT_W, 3, width of the occupancy and credit counters; must be at least log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address; word-aligned.
- imem_gnt_i  in  1  request accepted this cycle (req&&gnt = one issue).
- imem_rvalid_i  in  1  response valid; responses return in issue order, at least 1 cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch address; bits [1:0] are forced to 0.
- inst_valid_o  out  1  FIFO head valid.
- inst_ready_i  in  1  decode accepts the head (pop = valid&&ready).
- inst_o  out  32  head instruction.
- inst_addr_o  out  32  head instruction address.
- fifo_cnt_o  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset values:
  - pc = RESET_PC; imem_req_o = 0; inst_valid_o = 0; fifo_cnt_o = 0.
  - inst_o = 0; inst_addr_o = 0.
  - Internal inflight, drop and pointer registers = 0.
- Cycle after rst deasserts: imem_req_o = 1 with imem_addr_o = RESET_PC.
- Credit rule: imem_req_o = !redirect_i && (fifo_cnt + inflight < FIFO_DEPTH).
  - Popping the head in the current cycle does not add credit until the next cycle.
- Request stability: while req && !gnt, imem_addr_o holds stable.
- On each issue (req&&gnt): pc += 4, with 32-bit wrap (32'hFFFF_FFFC -> 0). inflight += 1.
- Address tracking: a separate address FIFO (depth FIFO_DEPTH) records the issue address, so each rvalid is paired with its address.
- On rvalid:
  - inflight -= 1.
  - If drop > 0: discard the data and decrement drop.
  - Otherwise: write {rdata, addr} into the FIFO.
  - The entry becomes visible on inst_valid_o the next cycle (1-cycle latency from rvalid).
- Simultaneous events:
  - Issue and rvalid in the same cycle leave inflight unchanged.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
- FIFO never overflows because of the credit rule.
  - An rvalid arriving with inflight == 0 is a protocol error: ignored, state unchanged.
- Redirect (redirect_i = 1) takes effect on that clock edge:
  - FIFO emptied: inst_valid_o = 0 next cycle; fifo_cnt = 0.
  - pc = {redirect_pc_i[31:2], 2'b00}.
  - drop = inflight, counting post-edge outstanding requests that have not yet returned.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is honoured for handshake purposes; the entry is simply flushed.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Outputs inst_o, inst_addr_o and inst_valid_o come straight from the FIFO head registers (no combinational path from imem).
- rst asserted mid-operation: all state returns to reset values on that edge. Later rvalids from old requests are the memory's responsibility; the memory is also reset.

Optional Feature:
- Macro RISCV_IFETCH_PERF_EN.
- When defined, adds these outputs:
  - perf_fetch_cnt_o (32): number of FIFO pushes.
  - perf_drop_cnt_o (32): number of discarded responses.
  - perf_stall_cnt_o (32): cycles with inst_ready_i=1 && inst_valid_o=0.
- All three counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Reset, then gnt=1, 1-cycle rvalid, ready=1 -> addresses 0,4,8,12 issued in consecutive cycles; inst_valid_o first high 2 cycles after first grant with inst_addr_o=0.
- ready=0, gnt=1, FIFO_DEPTH=4 -> exactly 4 grants total, fifo_cnt_o reaches 4, imem_req_o stays 0 until a pop; one pop -> exactly one new request.
- gnt held 0 for 3 cycles -> imem_addr_o stable at the same value, pc not advanced, no entries written.
- Two requests in flight (addr 8,12), redirect_pc_i=32'h103 -> both responses discarded; next issue at 32'h100; first output inst_addr_o=32'h100.
- Redirect in the same cycle as rvalid and pop -> FIFO empty next cycle, drop = remaining inflight, no stale entry ever presented.
- rst pulse mid-stream with FIFO at 3 entries -> next cycle inst_valid_o=0, fifo_cnt_o=0; following request at RESET_PC.

Source files
------------

// File: rtl/riscv_ifetch_buf.sv
// riscv_ifetch_buf: PC owner, pipelined imem fetch with credit-based instruction FIFO and redirect flush; optional perf counters under RISCV_IFETCH_PERF_EN
module riscv_ifetch_buf #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [CNT_W-1:0] fifo_cnt_o
`ifdef RISCV_IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt_o,
  output logic [31:0]      perf_drop_cnt_o,
  output logic [31:0]      perf_stall_cnt_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] LP_DEPTH = (CNT_W+1)'(FIFO_DEPTH);
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_awptr;
  logic [PW-1:0]    r_arptr;
  logic [31:0]      r_data  [FIFO_DEPTH];
  logic [31:0]      r_iaddr [FIFO_DEPTH];
  logic [31:0]      r_amem  [FIFO_DEPTH];
  logic             w_issue;
  logic             w_rv;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W:0]   w_used;
  logic [CNT_W-1:0] w_inflight_nxt;

  // outputs from head registers, credit check and per-cycle event decode
  always_comb begin
    inst_valid_o   = r_cnt != '0;
    inst_o         = r_data[r_rptr];
    inst_addr_o    = r_iaddr[r_rptr];
    fifo_cnt_o     = r_cnt;
    imem_addr_o    = r_pc;
    w_used         = {1'b0, r_cnt} + {1'b0, r_inflight};
    imem_req_o     = !rst && !redirect_i && (w_used < LP_DEPTH);
    w_issue        = imem_req_o && imem_gnt_i;
    w_rv           = imem_rvalid_i && (r_inflight != '0);
    w_push         = w_rv && (r_drop == '0) && !redirect_i;
    w_pop          = inst_valid_o && inst_ready_i;
    w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_rv);
  end

  // PC, outstanding requests and responses still owed to the discard path
  always_ff @(posedge clk)
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_pc       <= redirect_i ? {redirect_pc_i[31:2], 2'b00} : w_issue ? r_pc + 32'd4 : r_pc;
      r_drop     <= redirect_i ? w_inflight_nxt : (w_rv && r_drop != '0) ? r_drop - CNT_W'(1) : r_drop;
    end

  // issue-address queue pairing each response with its request; survives redirect so dropped responses stay aligned
  always_ff @(posedge clk)
    if (rst) begin
      r_awptr <= '0;
      r_arptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_amem[i] <= '0;
    end else begin
      if (w_issue) begin
        r_amem[r_awptr] <= r_pc;
        r_awptr         <= r_awptr + PW'(1);
      end
      if (w_rv) r_arptr <= r_arptr + PW'(1);
    end

  // instruction FIFO; redirect empties it regardless of same-cycle push or pop
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i]  <= '0;
        r_iaddr[i] <= '0;
      end
    end else if (redirect_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr]  <= imem_rdata_i;
        r_iaddr[r_wptr] <= r_amem[r_arptr];
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end

`ifdef RISCV_IFETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_drop;
  logic [31:0] r_perf_stall;
  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_drop_cnt_o  = r_perf_drop;
  assign perf_stall_cnt_o = r_perf_stall;

  // saturating event counters: pushes, discarded responses, decode starved
  always_ff @(posedge clk)
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && r_perf_fetch != '1) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_rv && !w_push && r_perf_drop != '1) r_perf_drop <= r_perf_drop + 32'd1;
      if (inst_ready_i && !inst_valid_o && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
    end
`endif
endmodule
